mem_wb_stage: RTL and testbench

- Stage 4 (memory access) plus the MEM/WB pipeline register of the 5-stage MIPS pipeline; it sits directly downstream of the EX/MEM register.
- Resolves taken branches (PCSrc_M) for the fetch-stage PC mux.
- Performs data-memory loads and stores; presents the write-back result, address and enable to the register file one cycle later.
- Detects program halt, drains the pipeline and signals completion.

---
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage plus MEM/WB register, with halt -> drain -> done sequencing.
// Define MEM_DUMP_EN to stream the whole data memory out after the drain.
module mem_wb_stage #(
   parameter int MEM_WORDS    = 512,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic                         RegWriteEN_M,
   input  logic                         Mem2RegSEL_M,
   input  logic                         MemWriteEN_M,
   input  logic                         Branch_M,
   input  logic                         ZeroFlag_M,
   input  logic [31:0]                  ALUOut_M,
   input  logic [31:0]                  MemWriteData_M,
   input  logic [4:0]                   RegAddr3_M,
   input  logic                         Halt_M,
   output logic                         PCSrc_M,
   output logic                         RegWriteEN_W,
   output logic [4:0]                   RegAddr3_W,
   output logic [31:0]                  RegData_W,
   output logic                         AddrFault_W,
   output logic                         Done,
   output logic                         DumpValid,
   output logic [$clog2(MEM_WORDS)-1:0] DumpAddr,
   output logic [31:0]                  DumpData
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_drain_cnt;
   logic          r_done;

   logic [31:0]   r_mem [MEM_WORDS];

   logic          r_regwe;
   logic          r_mem2reg;
   logic          r_fault;
   logic [4:0]    r_regaddr;
   logic [31:0]   r_aluout;
   logic [31:0]   r_memrd;

   logic [AW-1:0] w_idx;
   logic          w_fault;
   logic [31:0]   w_rdata;
   logic          w_run;
   logic          w_store;
   logic          w_wb_we;
   logic          w_capture;
   logic          w_dump_last;

   // Byte address must be word aligned and fall inside the memory.
   assign w_idx   = ALUOut_M[AW+1:2];
   assign w_fault = (ALUOut_M[1:0] != 2'b00) || (ALUOut_M[31:AW+2] != '0);
   assign w_rdata = w_fault ? 32'd0 : r_mem[w_idx];

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state     <= RUN;
         r_drain_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == RUN)
            r_drain_cnt <= CW'(DRAIN_CYCLES - 1);
         else if (r_state == DRAIN && r_drain_cnt != '0)
            r_drain_cnt <= r_drain_cnt - CW'(1);
         if (w_next == DONE)
            r_done <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RUN:   if (Halt_M) w_next = DRAIN;
         DRAIN: if (r_drain_cnt == '0)
`ifdef MEM_DUMP_EN
                   w_next = DUMP;
`else
                   w_next = DONE;
`endif
         DUMP:  if (w_dump_last) w_next = DONE;
         DONE:  w_next = DONE;
      endcase
   end

   always_comb begin
      w_run     = (r_state == RUN);
      w_store   = MemWriteEN_M & w_run & ~Halt_M & ~w_fault;
      w_wb_we   = RegWriteEN_M & w_run & ~Halt_M;
      w_capture = (r_state != DONE);
      PCSrc_M   = Branch_M & ZeroFlag_M & w_run;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < MEM_WORDS; i++)
            r_mem[i] <= '0;
      end else if (w_store) begin
         r_mem[w_idx] <= MemWriteData_M;
      end
   end

   // MEM/WB register; frozen once the program is done.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_regwe   <= 1'b0;
         r_mem2reg <= 1'b0;
         r_fault   <= 1'b0;
         r_regaddr <= '0;
         r_aluout  <= '0;
         r_memrd   <= '0;
      end else if (w_capture) begin
         r_regwe   <= w_wb_we;
         r_mem2reg <= Mem2RegSEL_M;
         r_fault   <= (MemWriteEN_M | Mem2RegSEL_M) & w_fault;
         r_regaddr <= RegAddr3_M;
         r_aluout  <= ALUOut_M;
         r_memrd   <= w_rdata;
      end
   end

   assign RegWriteEN_W = r_regwe;
   assign RegAddr3_W   = r_regaddr;
   assign RegData_W    = r_mem2reg ? r_memrd : r_aluout;
   assign AddrFault_W  = r_fault;
   assign Done         = r_done;

`ifdef MEM_DUMP_EN
   logic          r_dump_vld;
   logic [AW-1:0] r_dump_addr;
   logic [31:0]   r_dump_data;

   assign w_dump_last = (r_dump_addr == AW'(MEM_WORDS - 1));

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_dump_vld  <= 1'b0;
         r_dump_addr <= '0;
         r_dump_data <= '0;
      end else if (r_state == DRAIN && w_next == DUMP) begin
         r_dump_vld  <= 1'b1;
         r_dump_addr <= '0;
         r_dump_data <= r_mem[0];
      end else if (r_state == DUMP) begin
         if (w_dump_last) begin
            r_dump_vld <= 1'b0;
         end else begin
            r_dump_addr <= r_dump_addr + AW'(1);
            r_dump_data <= r_mem[r_dump_addr + AW'(1)];
         end
      end
   end

   assign DumpValid = r_dump_vld;
   assign DumpAddr  = r_dump_addr;
   assign DumpData  = r_dump_data;
`else
   assign w_dump_last = 1'b1;
   assign DumpValid   = 1'b0;
   assign DumpAddr    = '0;
   assign DumpData    = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, randomized traffic
// against a word-array model, and hand-written halt / drain / reset sequences.
module tb_mem_wb_stage;

`ifdef MEM_DUMP_EN
   localparam int MW = 8;
`else
   localparam int MW = 16;
`endif
   localparam int AW = $clog2(MW);

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b1;
   logic          RegWriteEN_M, Mem2RegSEL_M, MemWriteEN_M, Branch_M, ZeroFlag_M, Halt_M;
   logic [31:0]   ALUOut_M, MemWriteData_M;
   logic [4:0]    RegAddr3_M;
   logic          PCSrc_M, RegWriteEN_W, AddrFault_W, Done, DumpValid;
   logic [4:0]    RegAddr3_W;
   logic [31:0]   RegData_W, DumpData;
   logic [AW-1:0] DumpAddr;

   mem_wb_stage #(.MEM_WORDS(MW), .DRAIN_CYCLES(2)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .RegWriteEN_M(RegWriteEN_M), .Mem2RegSEL_M(Mem2RegSEL_M), .MemWriteEN_M(MemWriteEN_M),
      .Branch_M(Branch_M), .ZeroFlag_M(ZeroFlag_M), .ALUOut_M(ALUOut_M),
      .MemWriteData_M(MemWriteData_M), .RegAddr3_M(RegAddr3_M), .Halt_M(Halt_M),
      .PCSrc_M(PCSrc_M), .RegWriteEN_W(RegWriteEN_W), .RegAddr3_W(RegAddr3_W),
      .RegData_W(RegData_W), .AddrFault_W(AddrFault_W), .Done(Done),
      .DumpValid(DumpValid), .DumpAddr(DumpAddr), .DumpData(DumpData)
   );

   always #5 CLOCK = ~CLOCK;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] mdl_mem [MW];

   typedef struct {
      logic        we, m2r, mw, br, zf;
      logic [31:0] alu, wd;
      logic [4:0]  ra;
      logic        e_pc, e_we;
      logic [4:0]  e_ra;
      logic [31:0] e_data;
      logic        e_flt;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, m2r, mw, br, zf, halt,
                        input logic [31:0] alu, wd, input logic [4:0] ra);
      RegWriteEN_M   = we;
      Mem2RegSEL_M   = m2r;
      MemWriteEN_M   = mw;
      Branch_M       = br;
      ZeroFlag_M     = zf;
      Halt_M         = halt;
      ALUOut_M       = alu;
      MemWriteData_M = wd;
      RegAddr3_M     = ra;
      #1;
   endtask

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   function automatic bit mdl_fault(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(MW * 4));
   endfunction

   task automatic mdl_clear;
      for (int i = 0; i < MW; i++) mdl_mem[i] = 32'd0;
   endtask

   task automatic rand_cycle;
      logic [31:0] a, wd, ed;
      logic        we, m2r, mw, br, zf, f;
      logic [4:0]  ra;
      case ($urandom_range(0, 5))
         4:       a = 32'($urandom_range(0, MW - 1) * 4 + $urandom_range(1, 3));
         5:       a = $urandom;
         default: a = 32'($urandom_range(0, MW - 1) * 4);
      endcase
      wd  = $urandom;
      ra  = 5'($urandom);
      we  = 1'($urandom);
      m2r = 1'($urandom);
      mw  = 1'($urandom);
      br  = 1'($urandom);
      zf  = 1'($urandom);
      f   = mdl_fault(a);
      if (!m2r)    ed = a;
      else if (f)  ed = 32'd0;
      else         ed = mdl_mem[a / 4];
      drive(we, m2r, mw, br, zf, 1'b0, a, wd, ra);
      chk("rnd_pcsrc", PCSrc_M, br & zf);
      tick;
      chk("rnd_we_w", RegWriteEN_W, we);
      chk("rnd_ra_w", RegAddr3_W, ra);
      chk("rnd_data_w", RegData_W, ed);
      chk("rnd_fault_w", AddrFault_W, (mw | m2r) & f);
      if (mw && !f) mdl_mem[a / 4] = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //              we    m2r   mw    br    zf    alu             wd             ra     pc    we_w  ra_w   data            flt
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12,         32'h55,        5'd0,  1'b0, 1'b0, 5'd0,  32'h12,         1'b1};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,         32'h0,         5'd5,  1'b0, 1'b1, 5'd5,  32'h0,          1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,         32'hDEADBEEF,  5'd0,  1'b0, 1'b0, 5'd0,  32'h10,         1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,         32'h0,         5'd5,  1'b0, 1'b1, 5'd5,  32'hDEADBEEF,   1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'(MW * 4),    32'h0,         5'd7,  1'b0, 1'b1, 5'd7,  32'h0,          1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234,       32'h0,         5'd3,  1'b1, 1'b1, 5'd3,  32'h1234,       1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE0000,   32'h0,         5'd31, 1'b0, 1'b1, 5'd31, 32'hCAFE0000,   1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11,         32'h0,         5'd2,  1'b0, 1'b1, 5'd2,  32'h0,          1'b1};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF0010,   32'h0,         5'd6,  1'b0, 1'b1, 5'd6,  32'h0,          1'b1};

      // Reset state
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      tick;
      tick;
      chk("rst_we_w", RegWriteEN_W, 1'b0);
      chk("rst_ra_w", RegAddr3_W, 5'd0);
      chk("rst_data_w", RegData_W, 32'd0);
      chk("rst_fault_w", AddrFault_W, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_dumpvalid", DumpValid, 1'b0);
      chk("rst_dumpaddr", 32'(DumpAddr), 32'd0);
      RESET = 1'b0;
      mdl_clear();

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].we, tbl[i].m2r, tbl[i].mw, tbl[i].br, tbl[i].zf, 1'b0,
               tbl[i].alu, tbl[i].wd, tbl[i].ra);
         chk($sformatf("vec%0d_pcsrc", i), PCSrc_M, tbl[i].e_pc);
         tick;
         chk($sformatf("vec%0d_we_w", i), RegWriteEN_W, tbl[i].e_we);
         chk($sformatf("vec%0d_ra_w", i), RegAddr3_W, tbl[i].e_ra);
         chk($sformatf("vec%0d_data_w", i), RegData_W, tbl[i].e_data);
         chk($sformatf("vec%0d_fault_w", i), AddrFault_W, tbl[i].e_flt);
         if (tbl[i].mw && !mdl_fault(tbl[i].alu)) mdl_mem[tbl[i].alu / 4] = tbl[i].wd;
      end

      // Randomized traffic
      for (int i = 0; i < 300; i++) rand_cycle();

      // Halt, drain, (dump), done
      drive(0, 0, 1, 0, 0, 0, 32'h0C, 32'h1234, 5'd0);
      tick;
      mdl_mem[3] = 32'h1234;
      drive(1, 0, 0, 1, 1, 1, 32'h77, 32'h0, 5'd9);
      chk("halt_pcsrc", PCSrc_M, 1'b1);
      tick;
      chk("halt_we_w", RegWriteEN_W, 1'b0);
      chk("halt_data_w", RegData_W, 32'h77);
      chk("halt_done_e0", Done, 1'b0);
      drive(1, 0, 1, 1, 1, 0, 32'h0C, 32'hBAD, 5'd9);
      chk("drain_pcsrc", PCSrc_M, 1'b0);
      tick;
      chk("drain_done_e1", Done, 1'b0);
      chk("drain_we_w", RegWriteEN_W, 1'b0);
      drive(1, 0, 1, 0, 0, 1, 32'h0C, 32'hBAD0, 5'd9);
      tick;
`ifdef MEM_DUMP_EN
      chk("dump_done_early", Done, 1'b0);
      for (int i = 0; i < MW; i++) begin
         chk($sformatf("dump%0d_valid", i), DumpValid, 1'b1);
         chk($sformatf("dump%0d_addr", i), 32'(DumpAddr), 32'(i));
         chk($sformatf("dump%0d_data", i), DumpData, mdl_mem[i]);
         tick;
      end
      chk("dump_end_valid", DumpValid, 1'b0);
      chk("dump_end_done", Done, 1'b1);
`else
      chk("done_e2", Done, 1'b1);
      chk("nodump_valid", DumpValid, 1'b0);
`endif
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 1, 1, 1, 32'h0C, 32'h5A5A, 5'd4);
         chk("done_pcsrc", PCSrc_M, 1'b0);
         tick;
         chk("done_sticky", Done, 1'b1);
         chk("done_we_w", RegWriteEN_W, 1'b0);
      end

      // Asynchronous reset in the middle of the halt sequence
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
      mdl_clear();
      drive(0, 0, 1, 0, 0, 0, 32'h0C, 32'h1234, 5'd0);
      tick;
      drive(1, 0, 0, 0, 0, 1, 32'h77, 32'h0, 5'd9);
      tick;
      chk("rst2_data_pre", RegData_W, 32'h77);
`ifdef MEM_DUMP_EN
      for (int i = 0; i < 6; i++) tick;
      chk("rst2_dump4_valid", DumpValid, 1'b1);
      chk("rst2_dump4_addr", 32'(DumpAddr), 32'd4);
`endif
      #2;
      RESET = 1'b1;
      #1;
      chk("arst_dumpvalid", DumpValid, 1'b0);
      chk("arst_dumpaddr", 32'(DumpAddr), 32'd0);
      chk("arst_done", Done, 1'b0);
      chk("arst_we_w", RegWriteEN_W, 1'b0);
      chk("arst_data_w", RegData_W, 32'd0);
      tick;
      RESET = 1'b0;
      drive(1, 1, 0, 1, 1, 0, 32'h0C, 32'h0, 5'd4);
      chk("post_rst_pcsrc", PCSrc_M, 1'b1);
      tick;
      chk("post_rst_we_w", RegWriteEN_W, 1'b1);
      chk("post_rst_load", RegData_W, 32'd0);
      chk("post_rst_done", Done, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
